// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory responder:
//   - dm_state_t : responder FSM states (IDLE, WAIT, RESP)
//   - dm_cnt_t   : 4-bit wait-state counter type (WAIT_CYCLES range 0..15)
//   - dm_err_t   : per-cause error flags for a captured request
//   - dm_check() : derives dm_err_t from a captured address and command
// -----------------------------------------------------------------------------
package dm_pkg;

   localparam int unsigned CNT_W = 4;

   typedef logic [CNT_W-1:0] dm_cnt_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dm_state_t;

   // One flag per rejection cause; a request is rejected when any is set.
   typedef struct packed {
      logic misaligned;    // addr[1:0] != 0
      logic out_of_range;  // word index >= DEPTH
      logic bad_cmd;       // read == write (both or neither)
   } dm_err_t;

   function automatic dm_err_t dm_check(input logic [31:0] addr,
                                        input logic        rd,
                                        input logic        wr,
                                        input int unsigned depth);
      dm_err_t e;
      e.misaligned   = (addr[1:0] != 2'b00);
      e.out_of_range = ({2'b00, addr[31:2]} >= depth);
      e.bad_cmd      = (rd == wr);
      return e;
   endfunction

endpackage

// File: rtl/dm_array.sv
// -----------------------------------------------------------------------------
// dm_array
// DEPTH x 32-bit storage, synchronous write, registered read. Contents are
// never reset.
// Ports:
//   clk      : clock
//   i_we     : write enable (writes i_wdata to word i_addr)
//   i_re     : read enable (loads word i_addr into o_rdata)
//   i_addr   : word index
//   i_wdata  : write data
//   o_rdata  : registered read data; holds its value while i_re is low
// -----------------------------------------------------------------------------
module dm_array #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
// Single-outstanding data-memory responder for a CPU memory stage. A request
// accepted in IDLE waits WAIT_CYCLES cycles, performs its access, then holds
// the response until the CPU takes it.
// Parameters:
//   DEPTH       : number of 32-bit words stored
//   WAIT_CYCLES : added wait states per access (0..15)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : request present          req_ready : responder can accept
//   req_addr    : byte address             req_wdata : store data
//   req_read    : load request             req_write : store request
//   rsp_valid   : response available       rsp_ready : CPU accepts response
//   rsp_rdata   : load data (0 for stores/errors)
//   rsp_err     : request was rejected
// -----------------------------------------------------------------------------
module dm_responder
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_read,
   input  logic        req_write,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam dm_cnt_t     WAIT_INIT = dm_cnt_t'(WAIT_CYCLES);

   dm_state_t   r_state;
   dm_cnt_t     r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_read;
   logic        r_write;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic        r_load_ok;

   dm_err_t     w_err;
   logic        w_bad;
   logic        w_access;
   logic        w_we;
   logic        w_re;
   logic [31:0] w_rdata;

   // Error decode works only on captured request fields, so nothing on req_*
   // reaches rsp_* combinationally.
   assign w_err    = dm_check(r_addr, r_read, r_write, DEPTH);
   assign w_bad    = |w_err;
   assign w_access = (r_state == WAIT) && (r_cnt == '0);
   assign w_we     = w_access && r_write && !w_bad;
   assign w_re     = w_access && r_read  && !w_bad;

   dm_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_addr  (r_addr[AW+1:2]),
      .i_wdata (r_wdata),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_read      <= 1'b0;
         r_write     <= 1'b0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_load_ok   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_read      <= req_read;
                  r_write     <= req_write;
                  r_cnt       <= WAIT_INIT;
                  r_req_ready <= 1'b0;
                  r_state     <= WAIT;
               end
            end
            WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  // Access edge: the array captures its read word on this
                  // same edge, so r_load_ok gates a value that is valid
                  // from the first RESP cycle onward.
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_bad;
                  r_load_ok   <= r_read && !w_bad;
                  r_state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_load_ok   <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_load_ok ? w_rdata : '0;

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
// Directed bench for dm_responder: a default build (WAIT_CYCLES=2, DEPTH=64)
// and a zero-wait build (WAIT_CYCLES=0). Inputs change 1 time unit after the
// rising edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_dm_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   logic        req_valid, req_ready, req_read, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   logic        req_valid_z, req_ready_z, req_read_z, req_write_z;
   logic [31:0] req_addr_z, req_wdata_z;
   logic        rsp_valid_z, rsp_ready_z, rsp_err_z;
   logic [31:0] rsp_rdata_z;

   int n_vec = 0;
   int n_err = 0;

   dm_responder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_read  (req_read),
      .req_write (req_write),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   dm_responder #(
      .WAIT_CYCLES (0)
   ) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid_z),
      .req_ready (req_ready_z),
      .req_addr  (req_addr_z),
      .req_wdata (req_wdata_z),
      .req_read  (req_read_z),
      .req_write (req_write_z),
      .rsp_valid (rsp_valid_z),
      .rsp_ready (rsp_ready_z),
      .rsp_rdata (rsp_rdata_z),
      .rsp_err   (rsp_err_z)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the default build: accept, wait for the
   // response (bounded), check it, then complete the handshake.
   task automatic xact(input string tag, input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic wr,
                       input logic [31:0] exp_d, input logic exp_e);
      int n;
      chk({tag, "/ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_addr = a; req_wdata = wd; req_read = rd; req_write = wr;
      step();
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_read = 1'b0; req_write = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin
         step();
         n++;
      end
      chk({tag, "/latency"}, 32'(n), 32'd3);
      chk({tag, "/rdata"}, rsp_rdata, exp_d);
      chk({tag, "/err"}, 32'(rsp_err), 32'(exp_e));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, "/idle_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
   endtask

   task automatic xact0(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic rd, input logic wr, input logic [31:0] exp_d);
      int n;
      req_valid_z = 1'b1; req_addr_z = a; req_wdata_z = wd; req_read_z = rd; req_write_z = wr;
      step();
      req_valid_z = 1'b0; req_read_z = 1'b0; req_write_z = 1'b0;
      n = 0;
      while (!rsp_valid_z && n < 20) begin
         step();
         n++;
      end
      chk({tag, "/latency"}, 32'(n), 32'd1);
      chk({tag, "/rdata"}, rsp_rdata_z, exp_d);
      chk({tag, "/err"}, 32'(rsp_err_z), 32'd0);
      rsp_ready_z = 1'b1;
      step();
      rsp_ready_z = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_read = 1'b0; req_write = 1'b0;
      rsp_ready = 1'b0;
      req_valid_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_read_z = 1'b0; req_write_z = 1'b0;
      rsp_ready_z = 1'b0;

      // Reset state
      #3;
      chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset/rsp_rdata", rsp_rdata, 32'd0);
      chk("reset/rsp_err", 32'(rsp_err), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("reset/req_ready", 32'(req_ready), 32'd1);

      // Store then load, plus the last legal word
      xact("st_10", 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 1'b0);
      xact("ld_10", 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
      xact("st_fc", 32'hFC, 32'h1111_1111, 1'b0, 1'b1, 32'h0, 1'b0);
      xact("ld_fc", 32'hFC, 32'h0, 1'b1, 1'b0, 32'h1111_1111, 1'b0);
      xact("st_00", 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h0, 1'b0);

      // Backpressure, with a competing request held during RESP and handshake
      req_valid = 1'b1; req_addr = 32'hFC; req_read = 1'b1; req_write = 1'b0;
      step();
      req_addr = 32'h10;
      step();
      step();
      step();
      chk("bp/valid_first", 32'(rsp_valid), 32'd1);
      chk("bp/rdata_first", rsp_rdata, 32'h1111_1111);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp/hold_valid", 32'(rsp_valid), 32'd1);
         chk("bp/hold_rdata", rsp_rdata, 32'h1111_1111);
         chk("bp/hold_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("bp/after_hs_valid", 32'(rsp_valid), 32'd0);
      chk("bp/after_hs_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0; req_read = 1'b0;
      chk("bp/next_accept", 32'(req_ready), 32'd0);
      step();
      step();
      step();
      chk("bp/next_valid", 32'(rsp_valid), 32'd1);
      chk("bp/next_rdata", rsp_rdata, 32'hDEAD_BEEF);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // Error cases; none may disturb memory
      xact("err_misalign", 32'h12, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      xact("err_st_range", 32'h100, 32'hBADB_AD00, 1'b0, 1'b1, 32'h0, 1'b1);
      xact("err_ld_range", 32'h100, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
      xact("err_rdwr", 32'hFC, 32'h0000_0BAD, 1'b1, 1'b1, 32'h0, 1'b1);
      xact("err_none", 32'h0, 32'h0000_0BAD, 1'b0, 1'b0, 32'h0, 1'b1);
      xact("post_err_fc", 32'hFC, 32'h0, 1'b1, 1'b0, 32'h1111_1111, 1'b0);
      xact("post_err_00", 32'h0, 32'h0, 1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0);

      // Reset during WAIT cancels the store
      xact("pre_20", 32'h20, 32'h1234_5678, 1'b0, 1'b1, 32'h0, 1'b0);
      req_valid = 1'b1; req_addr = 32'h20; req_wdata = 32'h5; req_read = 1'b0; req_write = 1'b1;
      step();
      req_valid = 1'b0; req_write = 1'b0;
      chk("rst_wait/busy", 32'(req_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_wait/req_ready", 32'(req_ready), 32'd1);
      chk("rst_wait/rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_wait/rsp_rdata", rsp_rdata, 32'd0);
      step();
      step();
      step();
      rst_n = 1'b1;
      step();
      xact("rst_wait/ld_20", 32'h20, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 1'b0);

      // Zero-wait build
      xact0("z_st_08", 32'h8, 32'h0000_0077, 1'b0, 1'b1, 32'h0);
      xact0("z_ld_08", 32'h8, 32'h0, 1'b1, 1'b0, 32'h0000_0077);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
